counter_sequencer: RTL
======================

// Module: counter_sequencer
// PURPOSE
//   Shares one WIDTH-bit up-counter between NREQ requesters. A requester asks
//   for a run of len+1 counts (0..len); round-robin arbitration grants the counter.
//   The block counts from 0 to the latched target, then returns a one-cycle done pulse.
//   It sits between client FSMs and the shared count datapath and owns sequencing.
// PARAMETERS
//   NREQ  = 4  number of requesters (>=2)
//   WIDTH = 8  counter and target width in bits
// PORTS
//   clock   in   1           rising-edge clock
//   reset   in   1           synchronous, active-low reset
//   req     in   NREQ        level request per requester
//   len     in   NREQ*WIDTH  packed targets; slice i = len[i*WIDTH +: WIDTH]
//   pause   in   1           freeze the run (present only with CNT_SEQ_PAUSE_EN)
//   grant   out  NREQ        one-hot owner of the counter; all-zero when idle
//   busy    out  1           high while a run is in progress (== |grant)
//   value   out  WIDTH       current count
//   done    out  NREQ        one-cycle completion pulse to the granted requester
// BEHAVIOUR
//   - Reset (reset==0 at a posedge): state=IDLE, grant=0, busy=0, value=0,
//     done=0, rr pointer=0. Reset overrides every other event, including mid-run.
//     An interrupted run produces no done.
//   - States: IDLE, RUN. done is registered and is asserted only in the first
//     IDLE cycle after a completed run.
//   - IDLE: if req!=0, pick the first set req[i] scanning i=ptr, ptr+1, ...
//     (mod NREQ). At that edge: grant=onehot(i), busy=1, value=0,
//     target=len slice i (len is sampled only here), state->RUN.
//   - RUN, normal: if value!=target then value<=value+1. If value==target, at the
//     next edge: done[i]=1 for one cycle, grant=0, busy=0, ptr=(i+1)%NREQ,
//     state->IDLE. value keeps the final count until the next grant.
//   - Latency: grant is high for target+1 cycles. done is asserted in the cycle
//     after grant falls. The next grant comes no earlier than one cycle after
//     done, so the gap between grants is at least 2 cycles with grant=0.
//   - target=0: grant is high for 1 cycle with value=0, then done.
//   - target=2^WIDTH-1: counts to the maximum and never wraps. No arithmetic
//     wrap is possible because counting stops at target.
//   - Abort: if req[i] of the granted requester is 0 at a RUN edge, that edge
//     sets grant=0, busy=0, state->IDLE and done stays 0. value holds.
//     ptr=(i+1)%NREQ. Abort takes priority over completion at the same edge.
//   - Other requesters' req changes during RUN are ignored until IDLE.
//   - A requester that keeps req high after done stays eligible, but only at its
//     round-robin turn.
// CONFIGURATION
//   CNT_SEQ_PAUSE_EN defined: the pause port exists. In RUN with pause=1, value
//     holds and completion is not evaluated; abort still applies. pause is
//     ignored in IDLE.
//   Not defined: there is no pause port and runs are never stalled.
// TESTING
//   1 req=0001, len0=3 -> grant=0001 for 4 cycles, value 0,1,2,3; next cycle
//     done=0001 for 1 cycle, busy=0; value stays 3.
//   2 After reset, req=1111, all len=1 -> grants 0001,0010,0100,1000, each
//     2 cycles long, with 2 grant-free cycles between them. Each done pulses once.
//   3 Ptr=3 after serving requester 2, then req=0101 -> requester 0 is granted
//     first, then requester 2.
//   4 req[1] with len1=10; drop req[1] when value=4 -> next edge grant=0,
//     busy=0, done=0, value=4.
//   5 reset=0 while RUN at value=5 -> next edge grant=0, busy=0, value=0,
//     done=0; after release, req=0001 is granted with ptr=0.
//   6 (CNT_SEQ_PAUSE_EN) len0=2, pause=1 for 3 cycles at value=1 -> value holds
//     1 for 3 cycles, then 2, then done; grant is high for 6 cycles.

Source files
------------

// File: rtl/counter_sequencer.sv
// counter_sequencer: round-robin sharing of one WIDTH-bit up-counter among
// NREQ requesters. The winner gets a run 0..len[i], then a one-cycle done pulse.
// Optional feature: define CNT_SEQ_PAUSE_EN to add the pause input, which
// freezes an active run.
// Handshake: req is a level. grant is one-hot while the counter is owned.
// Dropping the owner's req aborts the run with no done. done fires once,
// registered, in the first idle cycle after a completed run.
// fsm_state exposes the FSM state (0 = IDLE, 1 = RUN) for debug and checkers.
module counter_sequencer #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   len,
`ifdef CNT_SEQ_PAUSE_EN
    input  logic                    pause,
`endif
    output logic [NREQ-1:0]         grant,
    output logic                    busy,
    output logic [WIDTH-1:0]        value,
    output logic [NREQ-1:0]         done,
    output logic                    fsm_state
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state, state_n;
    logic [NREQ-1:0]   grant_n;
    logic [WIDTH-1:0]  value_n;
    logic [NREQ-1:0]   done_n;
    logic [WIDTH-1:0]  target, target_n;
    logic [IW-1:0]     own, own_n;
    logic [IW-1:0]     ptr, ptr_n;
    logic [IW-1:0]     own_next;
    logic              pick_found;
    logic [IW-1:0]     pick_idx;
    logic [IW-1:0]     scan_j;
    logic              hold;

`ifdef CNT_SEQ_PAUSE_EN
    assign hold = pause;
`else
    assign hold = 1'b0;
`endif

    assign busy      = |grant;
    assign fsm_state = logic'(state);
    assign own_next  = (own == IW'(NREQ - 1)) ? '0 : own + 1'b1;

    // Round-robin scan: first requester at or after ptr, wrapping modulo NREQ.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        scan_j     = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_j = IW'((int'(ptr) + k) % NREQ);
            if (!pick_found && req[scan_j]) begin
                pick_found = 1'b1;
                pick_idx   = scan_j;
            end
        end
    end

    // Next-state logic: grant in IDLE, count / complete / abort in RUN.
    always_comb begin
        state_n  = state;
        grant_n  = grant;
        value_n  = value;
        done_n   = '0;
        target_n = target;
        own_n    = own;
        ptr_n    = ptr;
        case (state)
            IDLE: begin
                // The cycle carrying done is a mandatory cool-down before the
                // next grant, giving at least two grant-free cycles per hand-over.
                if (pick_found && (done == '0)) begin
                    grant_n           = '0;
                    grant_n[pick_idx] = 1'b1;
                    value_n           = '0;
                    target_n          = len[int'(pick_idx)*WIDTH +: WIDTH];
                    own_n             = pick_idx;
                    state_n           = RUN;
                end
            end
            RUN: begin
                if (!req[own]) begin
                    // Abort wins over completion; value keeps its last count.
                    grant_n = '0;
                    ptr_n   = own_next;
                    state_n = IDLE;
                end else if (!hold) begin
                    if (value != target) begin
                        value_n = value + 1'b1;
                    end else begin
                        done_n  = grant;
                        grant_n = '0;
                        ptr_n   = own_next;
                        state_n = IDLE;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                grant_n = '0;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state  <= IDLE;
            grant  <= '0;
            value  <= '0;
            done   <= '0;
            target <= '0;
            own    <= '0;
            ptr    <= '0;
        end else begin
            state  <= state_n;
            grant  <= grant_n;
            value  <= value_n;
            done   <= done_n;
            target <= target_n;
            own    <= own_n;
            ptr    <= ptr_n;
        end
    end

endmodule
